// File: rtl/idwt_upsmpl.sv
`default_nettype none
// ============================================================================
// Module      : idwt_upsmpl
// Description : Inverse-DWT upsampler front end. Buffers approximation (A)
//               and detail (D) coefficients in two independent FIFOs and
//               emits them pairwise, each coefficient pair followed by an
//               inserted-zero pair, to feed the synthesis filter stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W        coefficient width in bits (signed data, passed unmodified)
//   DEPTH    per-channel FIFO depth, power of 2, >= 4
// Ports
//   iclk        in   1  clock, rising edge
//   irst_n      in   1  synchronous active-low reset (overrides iclk_ena)
//   iclk_ena    in   1  clock enable; every register advances only when 1
//   ia_val      in   1  approximation coefficient valid
//   ia_dat      in   W  approximation coefficient
//   id_val      in   1  detail coefficient valid
//   id_dat      in   W  detail coefficient
//   oa_full     out  1  approximation FIFO full
//   od_full     out  1  detail FIFO full
//   oval        out  1  output pair valid (downstream qualifies with iclk_ena)
//   oa_dat      out  W  upsampled approximation sample
//   od_dat      out  W  upsampled detail sample
//   ophase      out  1  0 = coefficient slot, 1 = inserted-zero slot
//   oovf        out  1  sticky overflow flag
// Build option
//   IDWT_UPSMPL_OVF_EN  when defined, oovf latches on any dropped write;
//                       otherwise oovf is tied to 0.
// ============================================================================
module idwt_upsmpl #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         iclk_ena,
    input  logic         ia_val,
    input  logic [W-1:0] ia_dat,
    input  logic         id_val,
    input  logic [W-1:0] id_dat,
    output logic         oa_full,
    output logic         od_full,
    output logic         oval,
    output logic [W-1:0] oa_dat,
    output logic [W-1:0] od_dat,
    output logic         ophase,
    output logic         oovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2
    } state_t;

    // Channel 0 = approximation, channel 1 = detail.
    logic [1:0]   wr_val;
    logic [W-1:0] wr_dat [2];
    logic [1:0]   full;
    logic [1:0]   empty;
    logic [1:0]   push;
    logic [W-1:0] head   [2];
    logic         pop;   // shared: both FIFOs always pop together

    assign wr_val    = {id_val, ia_val};
    assign wr_dat[0] = ia_dat;
    assign wr_dat[1] = id_dat;

    // ------------------------------------------------------------------------
    // Coefficient FIFOs
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < 2; c++) begin : g_fifo
        logic [W-1:0]  mem_q [DEPTH];
        logic [AW-1:0] wptr_q;
        logic [AW-1:0] rptr_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Full comes from the registered count, so a write arriving while
        // full is dropped even if a pop frees a slot in the same cycle.
        assign full[c]  = (cnt_q == CW'(DEPTH));
        assign empty[c] = (cnt_q == '0);
        assign push[c]  = iclk_ena & wr_val[c] & ~full[c];
        assign head[c]  = mem_q[rptr_q];
        assign cnt_d    = cnt_q + CW'(push[c]) - CW'(pop);

        // Storage carries no reset; validity is tracked by the pointers.
        always_ff @(posedge iclk) begin
            if (push[c]) begin
                mem_q[wptr_q] <= wr_dat[c];
            end
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge iclk) begin
            if (!irst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[c]) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                cnt_q <= cnt_d;
            end
        end
    end

    assign oa_full = full[0];
    assign od_full = full[1];

    // ------------------------------------------------------------------------
    // Upsampling FSM
    // ------------------------------------------------------------------------
    state_t       state_q, state_d;
    logic         oval_q,  oval_d;
    logic [W-1:0] oa_q,    oa_d;
    logic [W-1:0] od_q,    od_d;
    logic         ph_q,    ph_d;
    logic         pair_rdy;

    assign pair_rdy = ~empty[0] & ~empty[1];

    always_comb begin
        state_d = state_q;
        oval_d  = oval_q;
        oa_d    = oa_q;
        od_d    = od_q;
        ph_d    = ph_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE, S_ODD: begin
                if (pair_rdy) begin
                    pop     = iclk_ena;
                    state_d = S_EVEN;
                    oval_d  = 1'b1;
                    oa_d    = head[0];
                    od_d    = head[1];
                    ph_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    oval_d  = 1'b0;
                end
            end
            S_EVEN: begin
                // Inserted-zero slot always follows a coefficient slot.
                state_d = S_ODD;
                oval_d  = 1'b1;
                oa_d    = '0;
                od_d    = '0;
                ph_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                oval_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q <= S_IDLE;
            oval_q  <= 1'b0;
            oa_q    <= '0;
            od_q    <= '0;
            ph_q    <= 1'b0;
        end else if (iclk_ena) begin
            state_q <= state_d;
            oval_q  <= oval_d;
            oa_q    <= oa_d;
            od_q    <= od_d;
            ph_q    <= ph_d;
        end
    end

    assign oval   = oval_q;
    assign oa_dat = oa_q;
    assign od_dat = od_q;
    assign ophase = ph_q;

    // ------------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------------
`ifdef IDWT_UPSMPL_OVF_EN
    logic [1:0] drop;
    logic       ovf_q;

    assign drop = {iclk_ena & id_val & full[1], iclk_ena & ia_val & full[0]};

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            ovf_q <= 1'b0;
        end else if (|drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign oovf = ovf_q;
`else
    assign oovf = 1'b0;
`endif

endmodule
`default_nettype wire
